alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Control stage directly upstream of the 4-to-16 function decoder in the 4-bit 16-function ALU. Accepts one operation (4-bit opcode plus two 4-bit operands) through a valid/ready handshake and registers it. It drives the opcode bits onto the decoder select inputs and the operands onto the ALU, holding both stable for a programmable settle time. It then captures the ALU result and flags and presents them through an output valid/ready handshake.

Parameters:
EXEC_CYCLES, 1, number of clock cycles the opcode and operands are held before the result is sampled; legal range 1..15.
CNT_W, 8, width of the completed-operation counter.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  upstream offers an operation.
in_ready  output  1  block can accept an operation this cycle.
in_op  input  4  opcode; bit 3 is MSB.
in_a  input  4  operand A.
in_b  input  4  operand B.
dec_sel_a  output  1  decoder select MSB, equal to op[3].
dec_sel_b  output  1  decoder select, equal to op[2].
dec_sel_c  output  1  decoder select, equal to op[1].
dec_sel_d  output  1  decoder select LSB, equal to op[0].
alu_a  output  4  registered operand A to the ALU.
alu_b  output  4  registered operand B to the ALU.
alu_y  input  4  ALU result; combinational from the decoder, alu_a and alu_b.
alu_cout  input  1  ALU carry/borrow out.
out_valid  output  1  result available.
out_ready  input  1  downstream accepts the result.
out_op  output  4  opcode of the presented result.
out_y  output  4  captured result.
out_cout  output  1  captured carry.
out_zero  output  1  1 when the captured alu_y is 4'b0000.
busy  output  1  1 in EXEC or RESP.
op_count  output  CNT_W  completed (output-accepted) operations.

Behaviour:
- Reset (async assert, sync-free release): state=IDLE.
  - All outputs are 0: dec_sel_*=0, alu_a=alu_b=0, out_*=0, out_valid=0, busy=0, op_count=0, exec counter=0.
  - in_ready=1 once in IDLE.
  - Reset mid-operation discards the operation; no result is produced and op_count is not incremented.
- States:
  - IDLE: in_ready=1.
  - EXEC: holding the op for EXEC_CYCLES cycles.
  - RESP: out_valid=1.
- in_ready = (state==IDLE) | (state==RESP & out_ready). This is a combinational path from out_ready; no other combinational input-to-output paths exist.
- Accept: in_valid & in_ready at edge T.
  - op_reg, alu_a and alu_b load from in_op, in_a and in_b.
  - exec counter loads 0.
  - state moves to EXEC.
  - dec_sel_* reflect op_reg from T onward.
- EXEC:
  - The counter increments each edge.
  - On the edge where counter == EXEC_CYCLES-1:
    - capture alu_y into out_y and alu_cout into out_cout;
    - out_zero = (alu_y==0);
    - out_op = op_reg;
    - state moves to RESP.
  - First out_valid=1 appears after edge T+EXEC_CYCLES.
  - in_valid is ignored in EXEC (in_ready=0).
- RESP:
  - out_valid=1; out_* are stable while out_ready=0 (indefinite stall allowed).
  - Edge with out_ready=1: op_count increments, wrapping from all-ones to 0.
    - If in_valid=1 in that same cycle: the new op is accepted (back-to-back), state goes to EXEC, and out_valid drops the next cycle.
    - Otherwise state goes to IDLE and out_valid=0.
- dec_sel_*, alu_a and alu_b hold the last op in IDLE; they change only on accept.
- busy = (state != IDLE).
- Throughput with no stall is one op per EXEC_CYCLES+1 cycles.

Test Plan:
- Reset/idle: assert rst_n=0 mid-cycle -> all outputs 0 immediately; after release in_ready=1, out_valid=0, op_count=0.
- Single op, EXEC_CYCLES=1, bench ALU is an adder for op 4'b0000: in_op=0, in_a=9, in_b=7 accepted at T -> dec_sel_a..d=0000 and alu_a=9/alu_b=7 from T; out_valid=1 after T+1 with out_y=0, out_cout=1, out_zero=1; out_ready=1 -> op_count=1.
- Latency: EXEC_CYCLES=3, in_op=4'b1010, a=5, b=3, ALU returns 8 -> dec_sel=1,0,1,0; out_valid first high after T+3; out_y=8, out_cout=0, out_zero=0.
- Stall and ignore: hold out_ready=0 for 10 cycles in RESP with in_valid=1 and changing in_op -> in_ready=0; out_* unchanged; dec_sel unchanged; op_count unchanged.
- Back-to-back: in RESP, out_ready=1 and in_valid=1 (op 4'b1111) on the same edge -> op_count increments, state goes to EXEC, dec_sel=1111 the next cycle, no IDLE cycle in between.
- Wrap and reset mid-op: 256 completed ops -> op_count returns to 0; assert rst_n low during EXEC -> no out_valid, op_count=0 after reset.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: operation request and result response handshake bundle
interface alu_op_sequencer_if;
  logic in_valid, in_ready, out_valid, out_ready, out_cout, out_zero;
  logic [3:0] in_op, in_a, in_b, out_op, out_y;
  modport master(
    output in_valid, in_op, in_a, in_b, out_ready,
    input in_ready, out_valid, out_op, out_y, out_cout, out_zero
  );
  modport slave(
    input in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_op, out_y, out_cout, out_zero
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: registers one ALU op, holds it for EXEC_CYCLES, then presents the captured result
module alu_op_sequencer #(
  parameter int EXEC_CYCLES = 1,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  alu_op_sequencer_if.slave bus,
  output logic dec_sel_a,
  output logic dec_sel_b,
  output logic dec_sel_c,
  output logic dec_sel_d,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [3:0] alu_y,
  input  logic alu_cout,
  output logic busy,
  output logic [CNT_W-1:0] op_count
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam logic [3:0] LAST = 4'(EXEC_CYCLES - 1);
  state_t state, state_nx;
  logic [3:0] op_reg, cnt;
  logic accept, done, fire;
  assign accept = bus.in_valid & bus.in_ready;
  assign done = (state == EXEC) && (cnt == LAST);
  assign fire = (state == RESP) && bus.out_ready;
  assign {dec_sel_a, dec_sel_b, dec_sel_c, dec_sel_d} = op_reg;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // accept has priority so a retire with a new request goes straight back to EXEC
  always_comb begin
    state_nx = accept ? EXEC : done ? RESP : fire ? IDLE : state;
  end
  always_comb begin
    bus.in_ready = (state == IDLE) | ((state == RESP) & bus.out_ready);
    bus.out_valid = state == RESP;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_reg <= '0;
      alu_a <= '0;
      alu_b <= '0;
      cnt <= '0;
      bus.out_op <= '0;
      bus.out_y <= '0;
      bus.out_cout <= 1'b0;
      bus.out_zero <= 1'b0;
      op_count <= '0;
    end else begin
      if (accept) begin
        op_reg <= bus.in_op;
        alu_a <= bus.in_a;
        alu_b <= bus.in_b;
        cnt <= '0;
      end else if (state == EXEC) cnt <= cnt + 4'd1;
      if (done) begin
        bus.out_op <= op_reg;
        bus.out_y <= alu_y;
        bus.out_cout <= alu_cout;
        bus.out_zero <= alu_y == 4'd0;
      end
      if (fire) op_count <= op_count + CNT_W'(1);
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed vectors on two instances (EXEC_CYCLES 1 and 3) with an adder as the ALU
module tb_alu_op_sequencer;
  logic clk, rst_n;
  alu_op_sequencer_if b1();
  alu_op_sequencer_if b3();
  logic [3:0] sel1, sel3, a1, bb1, a3, bb3, y1, y3;
  logic c1, c3, busy1, busy3;
  logic [7:0] cnt1, cnt3;
  assign {c1, y1} = 5'(a1) + 5'(bb1);
  assign {c3, y3} = 5'(a3) + 5'(bb3);
  alu_op_sequencer #(.EXEC_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1),
    .dec_sel_a(sel1[3]), .dec_sel_b(sel1[2]), .dec_sel_c(sel1[1]), .dec_sel_d(sel1[0]),
    .alu_a(a1), .alu_b(bb1), .alu_y(y1), .alu_cout(c1), .busy(busy1), .op_count(cnt1)
  );
  alu_op_sequencer #(.EXEC_CYCLES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .bus(b3),
    .dec_sel_a(sel3[3]), .dec_sel_b(sel3[2]), .dec_sel_c(sel3[1]), .dec_sel_d(sel3[0]),
    .alu_a(a3), .alu_b(bb3), .alu_y(y3), .alu_cout(c3), .busy(busy3), .op_count(cnt3)
  );
  typedef struct {
    logic [3:0] op, a, b, y;
    logic cout, zero;
  } vec_t;
  vec_t vecs [6];
  int tests = 0, fails = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic wait1();
    int n = 0;
    while (b1.out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (b1.out_valid !== 1'b1) chk("u1_result_timeout", {31'd0, b1.out_valid}, 1);
  endtask
  task automatic issue1(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    b1.in_valid = 1'b1;
    b1.in_op = op;
    b1.in_a = a;
    b1.in_b = b;
    @(negedge clk);
    b1.in_valid = 1'b0;
    wait1();
  endtask
  task automatic retire1();
    b1.out_ready = 1'b1;
    @(negedge clk);
    b1.out_ready = 1'b0;
  endtask
  task automatic chk_zero(input string n);
    chk({n, "_busy"}, {31'd0, busy1 | busy3}, 0);
    chk({n, "_out_valid"}, {31'd0, b1.out_valid | b3.out_valid}, 0);
    chk({n, "_sel"}, {24'd0, sel1, sel3}, 0);
    chk({n, "_alu_ops"}, {16'd0, a1, bb1, a3, bb3}, 0);
    chk({n, "_out_y_op"}, {16'd0, b1.out_y, b1.out_op, b3.out_y, b3.out_op}, 0);
    chk({n, "_flags"}, {28'd0, b1.out_cout, b1.out_zero, b3.out_cout, b3.out_zero}, 0);
    chk({n, "_op_count"}, {16'd0, cnt1, cnt3}, 0);
  endtask
  initial begin
    vecs[0] = '{4'h0, 4'd9, 4'd7, 4'h0, 1'b1, 1'b1};
    vecs[1] = '{4'hA, 4'd5, 4'd3, 4'h8, 1'b0, 1'b0};
    vecs[2] = '{4'hF, 4'd15, 4'd15, 4'hE, 1'b1, 1'b0};
    vecs[3] = '{4'h3, 4'd0, 4'd0, 4'h0, 1'b0, 1'b1};
    vecs[4] = '{4'h5, 4'd12, 4'd3, 4'hF, 1'b0, 1'b0};
    vecs[5] = '{4'h8, 4'd8, 4'd8, 4'h0, 1'b1, 1'b1};
    rst_n = 1'b1;
    {b1.in_valid, b1.out_ready, b3.in_valid, b3.out_ready} = '0;
    {b1.in_op, b1.in_a, b1.in_b, b3.in_op, b3.in_a, b3.in_b} = '0;
    #3 rst_n = 1'b0;
    #1 chk_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", {30'd0, b1.in_ready, b3.in_ready}, 3);
    chk("idle_out_valid", {30'd0, b1.out_valid, b3.out_valid}, 0);
    chk("idle_op_count", {16'd0, cnt1, cnt3}, 0);
    // single op on the 1-cycle instance
    b1.in_valid = 1'b1;
    b1.in_op = 4'h0;
    b1.in_a = 4'd9;
    b1.in_b = 4'd7;
    @(negedge clk);
    b1.in_valid = 1'b0;
    chk("single_sel", {28'd0, sel1}, 0);
    chk("single_alu_ops", {24'd0, a1, bb1}, 32'h97);
    chk("single_exec_state", {29'd0, busy1, b1.out_valid, b1.in_ready}, 32'b100);
    @(negedge clk);
    chk("single_out_valid", {31'd0, b1.out_valid}, 1);
    chk("single_result", {26'd0, b1.out_y, b1.out_cout, b1.out_zero}, {26'd0, 4'h0, 1'b1, 1'b1});
    retire1();
    chk("single_op_count", {24'd0, cnt1}, 1);
    chk("single_back_idle", {30'd0, b1.out_valid, busy1}, 0);
    for (int i = 0; i < 6; i++) begin
      issue1(vecs[i].op, vecs[i].a, vecs[i].b);
      chk($sformatf("vec%0d_y", i), {28'd0, b1.out_y}, {28'd0, vecs[i].y});
      chk($sformatf("vec%0d_flags", i), {30'd0, b1.out_cout, b1.out_zero}, {30'd0, vecs[i].cout, vecs[i].zero});
      chk($sformatf("vec%0d_op_sel", i), {24'd0, b1.out_op, sel1}, {24'd0, vecs[i].op, vecs[i].op});
      retire1();
      chk($sformatf("vec%0d_op_count", i), {24'd0, cnt1}, i + 2);
    end
    // latency on the 3-cycle instance
    b3.in_valid = 1'b1;
    b3.in_op = 4'hA;
    b3.in_a = 4'd5;
    b3.in_b = 4'd3;
    @(negedge clk);
    b3.in_valid = 1'b0;
    chk("lat_sel", {28'd0, sel3}, 32'hA);
    chk("lat_t0_valid", {30'd0, busy3, b3.out_valid}, 32'b10);
    @(negedge clk);
    chk("lat_t1_valid", {31'd0, b3.out_valid}, 0);
    @(negedge clk);
    chk("lat_t2_valid", {31'd0, b3.out_valid}, 0);
    @(negedge clk);
    chk("lat_t3_valid", {31'd0, b3.out_valid}, 1);
    chk("lat_result", {22'd0, b3.out_op, b3.out_y, b3.out_cout, b3.out_zero}, {22'd0, 4'hA, 4'h8, 2'b00});
    // stall with new requests offered and ignored
    for (int j = 0; j < 10; j++) begin
      b3.in_valid = 1'b1;
      b3.in_op = 4'(j);
      b3.in_a = 4'(j + 1);
      #1 chk($sformatf("stall%0d_in_ready", j), {31'd0, b3.in_ready}, 0);
      @(negedge clk);
      chk($sformatf("stall%0d_hold", j), {15'd0, b3.out_valid, b3.out_y, sel3, cnt3}, {15'd0, 1'b1, 4'h8, 4'hA, 8'd0});
    end
    // back-to-back retire and accept
    b3.in_op = 4'hF;
    b3.in_a = 4'd1;
    b3.in_b = 4'd2;
    b3.out_ready = 1'b1;
    #1 chk("b2b_in_ready", {31'd0, b3.in_ready}, 1);
    @(negedge clk);
    b3.in_valid = 1'b0;
    b3.out_ready = 1'b0;
    chk("b2b_count", {24'd0, cnt3}, 1);
    chk("b2b_exec", {26'd0, busy3, b3.out_valid, sel3}, {26'd0, 2'b10, 4'hF});
    repeat (2) @(negedge clk);
    chk("b2b_t2_valid", {31'd0, b3.out_valid}, 0);
    @(negedge clk);
    chk("b2b_result", {23'd0, b3.out_valid, b3.out_op, b3.out_y}, {23'd0, 1'b1, 4'hF, 4'h3});
    b3.out_ready = 1'b1;
    @(negedge clk);
    b3.out_ready = 1'b0;
    chk("b2b_count2", {24'd0, cnt3}, 2);
    // counter wrap on the 1-cycle instance
    for (int k = 0; k < 248; k++) begin
      issue1(4'(k), 4'(k), 4'(k >> 4));
      retire1();
    end
    chk("wrap_pre", {24'd0, cnt1}, 255);
    issue1(4'h1, 4'd1, 4'd1);
    retire1();
    chk("wrap_zero", {24'd0, cnt1}, 0);
    issue1(4'h2, 4'd2, 4'd2);
    retire1();
    chk("wrap_one", {24'd0, cnt1}, 1);
    // reset while both instances are executing
    @(negedge clk);
    {b1.in_valid, b3.in_valid} = 2'b11;
    {b1.in_op, b1.in_a, b1.in_b} = {4'h6, 4'd2, 4'd3};
    {b3.in_op, b3.in_a, b3.in_b} = {4'h7, 4'd4, 4'd4};
    @(negedge clk);
    {b1.in_valid, b3.in_valid} = 2'b00;
    chk("midop_busy", {30'd0, busy1, busy3}, 3);
    rst_n = 1'b0;
    #1 chk_zero("midop_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_reset_valid", {30'd0, b1.out_valid, b3.out_valid}, 0);
    chk("post_reset_ready", {30'd0, b1.in_ready, b3.in_ready}, 3);
    chk("post_reset_count", {16'd0, cnt1, cnt3}, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
